// File: rtl/dds_glide_osc.sv
// DDS voice oscillator: slews a phase increment toward the looked-up target (portamento), runs a
// 32-bit phase accumulator on the sample strobe and emits saw, pulse or triangle samples.
module dds_glide_osc #(
  parameter int unsigned          OUT_W    = 12,
  parameter logic [OUT_W-1:0]     MIDSCALE = {1'b1, {(OUT_W-1){1'b0}}}
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [31:0]      ADDER,
  input  logic             GATE,
  input  logic             SAMPLE_EN,
  input  logic [15:0]      GLIDE_STEP,
  input  logic [1:0]       WAVE_SEL,
  input  logic [7:0]       PW,
  output logic [31:0]      PHASE,
  output logic [OUT_W-1:0] WAVE_OUT,
  output logic             SAMPLE_VALID,
  output logic             GLIDING
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q;
  logic             gate_q;
  logic             sample_q;
  logic [31:0]      phase_q;
  logic [31:0]      cur_inc_q;
  logic [OUT_W-1:0] wave_q;
  logic             valid_q;
  logic             gliding_q;

  logic             gate_rise;
  logic             gate_fall;
  logic [31:0]      step32;
  logic [31:0]      diff_up;
  logic [31:0]      diff_dn;
  logic [31:0]      glide_inc;
  logic [OUT_W-1:0] tri_raw;
  logic [OUT_W-1:0] wave_val;

  assign gate_rise = GATE & ~gate_q;
  assign gate_fall = ~GATE & gate_q;

  // Step toward ADDER from the pre-update increment, clamping on the last step.
  always_comb begin
    step32    = {16'd0, GLIDE_STEP};
    diff_up   = ADDER - cur_inc_q;
    diff_dn   = cur_inc_q - ADDER;
    glide_inc = ADDER;
    if (GLIDE_STEP != 16'd0) begin
      if (cur_inc_q < ADDER) begin
        glide_inc = (diff_up <= step32) ? ADDER : cur_inc_q + step32;
      end else if (cur_inc_q > ADDER) begin
        glide_inc = (diff_dn <= step32) ? ADDER : cur_inc_q - step32;
      end
    end
  end

  always_comb begin
    tri_raw  = phase_q[30 -: OUT_W];
    wave_val = MIDSCALE;
    case (WAVE_SEL)
      2'd0:    wave_val = phase_q[31 -: OUT_W];
      2'd1:    wave_val = (phase_q[31:24] < PW) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
      2'd2:    wave_val = phase_q[31] ? ~tri_raw : tri_raw;
      default: wave_val = MIDSCALE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q   <= StIdle;
      gate_q    <= 1'b0;
      sample_q  <= 1'b0;
      phase_q   <= 32'd0;
      cur_inc_q <= 32'd0;
      wave_q    <= MIDSCALE;
      valid_q   <= 1'b0;
      gliding_q <= 1'b0;
    end else begin
      gate_q    <= GATE;
      sample_q  <= SAMPLE_EN;
      valid_q   <= sample_q;
      gliding_q <= (state_q == StRun) && (cur_inc_q != ADDER);
      // Output stream keeps running while idle so the mixer never stalls.
      if (sample_q) begin
        wave_q <= (state_q == StRun) ? wave_val : MIDSCALE;
      end
      unique case (state_q)
        StIdle: begin
          if (gate_rise) begin
            state_q   <= StRun;
            phase_q   <= 32'd0;
            cur_inc_q <= ADDER;
          end
        end
        StRun: begin
          if (gate_fall) begin
            state_q <= StIdle;
          end else if (SAMPLE_EN) begin
            phase_q   <= phase_q + cur_inc_q;
            cur_inc_q <= glide_inc;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign PHASE        = phase_q;
  assign WAVE_OUT     = wave_q;
  assign SAMPLE_VALID = valid_q;
  assign GLIDING      = gliding_q;

endmodule

// File: tb/tb_dds_glide_osc.sv
// Directed bench for dds_glide_osc: accumulation, glide, waveforms, gate handling and reset.
module tb_dds_glide_osc;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [31:0] ADDER;
  logic        GATE;
  logic        SAMPLE_EN;
  logic [15:0] GLIDE_STEP;
  logic [1:0]  WAVE_SEL;
  logic [7:0]  PW;
  logic [31:0] PHASE;
  logic [11:0] WAVE_OUT;
  logic        SAMPLE_VALID;
  logic        GLIDING;

  int errors = 0;
  int checks = 0;

  dds_glide_osc #(.OUT_W(12)) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .ADDER        (ADDER),
    .GATE         (GATE),
    .SAMPLE_EN    (SAMPLE_EN),
    .GLIDE_STEP   (GLIDE_STEP),
    .WAVE_SEL     (WAVE_SEL),
    .PW           (PW),
    .PHASE        (PHASE),
    .WAVE_OUT     (WAVE_OUT),
    .SAMPLE_VALID (SAMPLE_VALID),
    .GLIDING      (GLIDING)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Strobe once; on return the output stage has produced its sample.
  task automatic do_sample();
    SAMPLE_EN = 1'b1;
    step();
    SAMPLE_EN = 1'b0;
    step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ph;
    logic [31:0] m;
    logic [31:0] exp_w;
    logic [11:0] t;

    RESET_N = 1'b0; GATE = 1'b0; ADDER = 32'd0; SAMPLE_EN = 1'b0;
    GLIDE_STEP = 16'd0; WAVE_SEL = 2'd0; PW = 8'd128;
    step();
    step();
    check("rst_phase", PHASE, 32'd0);
    check("rst_wave", {20'd0, WAVE_OUT}, 32'd2048);
    check("rst_valid", {31'd0, SAMPLE_VALID}, 32'd0);
    check("rst_gliding", {31'd0, GLIDING}, 32'd0);

    // Note on straight out of silence, no glide
    ADDER = 32'd11237; GATE = 1'b1; RESET_N = 1'b1;
    step();
    check("on_phase", PHASE, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      SAMPLE_EN = 1'b1;
      step();
      SAMPLE_EN = 1'b0;
      check("acc_phase", PHASE, 32'(11237 * i));
      check("lat1_valid", {31'd0, SAMPLE_VALID}, 32'd0);
      step();
      check("lat2_valid", {31'd0, SAMPLE_VALID}, 32'd1);
      step();
      check("valid_1cyc", {31'd0, SAMPLE_VALID}, 32'd0);
      repeat (5) step();
    end
    check("acc4_phase", PHASE, 32'd44948);
    check("acc4_gliding", {31'd0, GLIDING}, 32'd0);

    // Upward glide 11237 -> 22473 in steps of 1000
    ADDER = 32'd22473; GLIDE_STEP = 16'd1000;
    step();
    check("up_gliding", {31'd0, GLIDING}, 32'd1);
    for (int i = 0; i < 11; i++) do_sample();
    check("up11_phase", PHASE, 32'd223555);
    ph = PHASE;
    SAMPLE_EN = 1'b1;
    step();
    SAMPLE_EN = 1'b0;
    check("up12_delta", PHASE - ph, 32'd22237);
    check("up12_gliding", {31'd0, GLIDING}, 32'd1);
    step();
    check("up_gliding_drop", {31'd0, GLIDING}, 32'd0);
    ph = PHASE;
    do_sample();
    check("up13_delta", PHASE - ph, 32'd22473);

    // Downward glide back to 11237
    ADDER = 32'd11237;
    step();
    check("dn_gliding", {31'd0, GLIDING}, 32'd1);
    for (int i = 0; i < 11; i++) do_sample();
    ph = PHASE;
    SAMPLE_EN = 1'b1;
    step();
    SAMPLE_EN = 1'b0;
    check("dn12_delta", PHASE - ph, 32'd11473);
    step();
    check("dn_gliding_drop", {31'd0, GLIDING}, 32'd0);
    ph = PHASE;
    do_sample();
    check("dn13_delta", PHASE - ph, 32'd11237);

    // Gate off: phase frozen, midscale samples keep flowing
    ph = PHASE;
    GATE = 1'b0;
    step();
    check("off_phase", PHASE, ph);
    do_sample();
    check("off_valid", {31'd0, SAMPLE_VALID}, 32'd1);
    check("off_wave", {20'd0, WAVE_OUT}, 32'd2048);
    check("off_phase_hold", PHASE, ph);

    // Re-rise with coincident strobe: phase reset, no glide from the old increment
    ADDER = 32'h0010_0000; GATE = 1'b1; SAMPLE_EN = 1'b1;
    step();
    SAMPLE_EN = 1'b0;
    check("rerise_phase", PHASE, 32'd0);
    step();
    check("rerise_valid", {31'd0, SAMPLE_VALID}, 32'd1);
    check("rerise_wave", {20'd0, WAVE_OUT}, 32'd0);
    do_sample();
    check("rerise_inc", PHASE, 32'h0010_0000);
    check("saw_1", {20'd0, WAVE_OUT}, 32'd1);
    GLIDE_STEP = 16'd0;

    // Saw over a full cycle, ending on the wrap
    for (int k = 2; k <= 4096; k++) begin
      do_sample();
      check("saw", {20'd0, WAVE_OUT}, 32'(k % 4096));
    end
    check("saw_wrap_phase", PHASE, 32'd0);

    // Pulse at 50%
    WAVE_SEL = 2'd1; PW = 8'd128;
    for (int k = 1; k <= 4096; k++) begin
      m = 32'(k % 4096);
      exp_w = (m < 32'd2048) ? 32'd4095 : 32'd0;
      do_sample();
      check("pulse50", {20'd0, WAVE_OUT}, exp_w);
    end
    PW = 8'd0;
    do_sample();
    check("pulse_pw0", {20'd0, WAVE_OUT}, 32'd0);
    PW = 8'd255;
    for (int k = 2; k <= 4096; k++) begin
      m = 32'(k % 4096);
      exp_w = ((m >> 4) < 32'd255) ? 32'd4095 : 32'd0;
      do_sample();
      check("pulse_pw255", {20'd0, WAVE_OUT}, exp_w);
    end

    // Triangle: rises 2..4094, then 4095 down with no step at the half-cycle
    WAVE_SEL = 2'd2;
    for (int k = 1; k <= 4096; k++) begin
      m = 32'(k % 4096);
      t = 12'((m % 32'd2048) * 32'd2);
      exp_w = {20'd0, (m >= 32'd2048) ? ~t : t};
      do_sample();
      check("triangle", {20'd0, WAVE_OUT}, exp_w);
    end

    WAVE_SEL = 2'd3;
    do_sample();
    check("silence_wave", {20'd0, WAVE_OUT}, 32'd2048);

    // Strobe held high advances once per cycle
    WAVE_SEL = 2'd0;
    SAMPLE_EN = 1'b1;
    repeat (3) step();
    SAMPLE_EN = 1'b0;
    check("held_phase", PHASE, 32'h0040_0000);
    step();
    check("held_valid", {31'd0, SAMPLE_VALID}, 32'd1);
    check("held_wave", {20'd0, WAVE_OUT}, 32'd4);

    // Reset mid-glide with gate held high through release
    ADDER = 32'h0020_0000; GLIDE_STEP = 16'd1;
    step();
    step();
    check("pre_rst_gliding", {31'd0, GLIDING}, 32'd1);
    RESET_N = 1'b0;
    step();
    check("mid_rst_phase", PHASE, 32'd0);
    check("mid_rst_wave", {20'd0, WAVE_OUT}, 32'd2048);
    check("mid_rst_valid", {31'd0, SAMPLE_VALID}, 32'd0);
    check("mid_rst_gliding", {31'd0, GLIDING}, 32'd0);
    RESET_N = 1'b1;
    step();
    check("rel_phase", PHASE, 32'd0);
    do_sample();
    check("rel_inc", PHASE, 32'h0020_0000);
    check("rel_wave", {20'd0, WAVE_OUT}, 32'd2);
    step();
    check("rel_gliding", {31'd0, GLIDING}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
